// File: rtl/rotor_step_controller.sv
// Step controller for a three-drum bombe rotor stack. It issues one-cycle
// increment pulses with odometer carry, keeps shadow positions, and acknowledges each step after it settles.
module rotor_step_controller #(
  parameter int SETTLE_CYCLES = 2,
  parameter int SWEEP_LEN     = 17576
) (
  input  logic        i_clk,
  input  logic        i_resetn,
  input  logic        i_load,
  input  logic [4:0]  i_init_fast,
  input  logic [4:0]  i_init_mid,
  input  logic [4:0]  i_init_slow,
  input  logic        i_step_req,
  output logic        o_step_ack,
  output logic        o_busy,
  output logic        o_inc_fast,
  output logic        o_inc_mid,
  output logic        o_inc_slow,
  output logic        o_load_rotors,
  output logic [4:0]  o_pos_fast,
  output logic [4:0]  o_pos_mid,
  output logic [4:0]  o_pos_slow,
  output logic [14:0] o_step_count,
  output logic        o_sweep_done
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST =
    (SETTLE_CYCLES > 0) ? CNT_W'(SETTLE_CYCLES - 1) : '0;
  localparam logic [14:0] SWEEP_MAX = 15'(SWEEP_LEN);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PULSE  = 2'd1,
    SETTLE = 2'd2,
    ACK    = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_settle_cnt;
  logic [4:0]       r_pos_fast;
  logic [4:0]       r_pos_mid;
  logic [4:0]       r_pos_slow;
  logic [14:0]      r_step_count;
  logic             r_sweep_done;
  logic             r_step_ack;
  logic             r_busy;
  logic             r_inc_fast;
  logic             r_inc_mid;
  logic             r_inc_slow;
  logic             r_load_rotors;

  function automatic logic [4:0] wrap_inc(input logic [4:0] pos);
    return (pos == 5'd25) ? 5'd0 : pos + 5'd1;
  endfunction

  // Drums only have positions 0..25; anything above that loads as 0.
  function automatic logic [4:0] sanitize(input logic [4:0] pos);
    return (pos > 5'd25) ? 5'd0 : pos;
  endfunction

  // Step FSM, shadow positions, step counter and registered pulse outputs.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state       <= IDLE;
      r_settle_cnt  <= '0;
      r_pos_fast    <= 5'd0;
      r_pos_mid     <= 5'd0;
      r_pos_slow    <= 5'd0;
      r_step_count  <= 15'd0;
      r_sweep_done  <= 1'b0;
      r_step_ack    <= 1'b0;
      r_busy        <= 1'b0;
      r_inc_fast    <= 1'b0;
      r_inc_mid     <= 1'b0;
      r_inc_slow    <= 1'b0;
      r_load_rotors <= 1'b0;
    end else begin
      r_load_rotors <= i_load;
      r_step_ack    <= 1'b0;
      r_inc_fast    <= 1'b0;
      r_inc_mid     <= 1'b0;
      r_inc_slow    <= 1'b0;
      if (i_load) begin
        // Load wins in every state and silently aborts any step in flight.
        r_state      <= IDLE;
        r_busy       <= 1'b0;
        r_settle_cnt <= '0;
        r_pos_fast   <= sanitize(i_init_fast);
        r_pos_mid    <= sanitize(i_init_mid);
        r_pos_slow   <= sanitize(i_init_slow);
        r_step_count <= 15'd0;
        r_sweep_done <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (i_step_req && !r_sweep_done) begin
              r_state    <= PULSE;
              r_busy     <= 1'b1;
              r_inc_fast <= 1'b1;
              r_inc_mid  <= (r_pos_fast == 5'd25);
              r_inc_slow <= (r_pos_fast == 5'd25) && (r_pos_mid == 5'd25);
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
          PULSE: begin
            r_pos_fast <= wrap_inc(r_pos_fast);
            if (r_pos_fast == 5'd25) begin
              r_pos_mid <= wrap_inc(r_pos_mid);
            end
            if ((r_pos_fast == 5'd25) && (r_pos_mid == 5'd25)) begin
              r_pos_slow <= wrap_inc(r_pos_slow);
            end
            if (r_step_count != SWEEP_MAX) begin
              r_step_count <= r_step_count + 15'd1;
            end
            if ((r_step_count + 15'd1) == SWEEP_MAX) begin
              r_sweep_done <= 1'b1;
            end
            r_settle_cnt <= '0;
            if (SETTLE_CYCLES > 0) begin
              r_state <= SETTLE;
            end else begin
              r_state    <= ACK;
              r_step_ack <= 1'b1;
            end
          end
          SETTLE: begin
            if (r_settle_cnt == SETTLE_LAST) begin
              r_state      <= ACK;
              r_step_ack   <= 1'b1;
              r_settle_cnt <= '0;
            end else begin
              r_settle_cnt <= r_settle_cnt + 1'b1;
            end
          end
          ACK: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_step_ack    = r_step_ack;
  assign o_busy        = r_busy;
  assign o_inc_fast    = r_inc_fast;
  assign o_inc_mid     = r_inc_mid;
  assign o_inc_slow    = r_inc_slow;
  assign o_load_rotors = r_load_rotors;
  assign o_pos_fast    = r_pos_fast;
  assign o_pos_mid     = r_pos_mid;
  assign o_pos_slow    = r_pos_slow;
  assign o_step_count  = r_step_count;
  assign o_sweep_done  = r_sweep_done;

endmodule

// File: tb/tb_rotor_step_controller.sv
// Directed, table-driven bench for rotor_step_controller: single steps with
// carry, load/reset corner cases and one full 26^3 sweep.
module tb_rotor_step_controller;

  logic        clk = 1'b0;
  logic        resetn;
  logic        load;
  logic [4:0]  init_fast, init_mid, init_slow;
  logic        step_req;
  logic        step_ack, busy, inc_fast, inc_mid, inc_slow, load_rotors;
  logic [4:0]  pos_fast, pos_mid, pos_slow;
  logic [14:0] step_count;
  logic        sweep_done;

  int n_chk  = 0;
  int n_fail = 0;

  rotor_step_controller dut (
    .i_clk(clk), .i_resetn(resetn), .i_load(load),
    .i_init_fast(init_fast), .i_init_mid(init_mid), .i_init_slow(init_slow),
    .i_step_req(step_req), .o_step_ack(step_ack), .o_busy(busy),
    .o_inc_fast(inc_fast), .o_inc_mid(inc_mid), .o_inc_slow(inc_slow),
    .o_load_rotors(load_rotors), .o_pos_fast(pos_fast), .o_pos_mid(pos_mid),
    .o_pos_slow(pos_slow), .o_step_count(step_count), .o_sweep_done(sweep_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] f, m, s;
    logic [4:0] ef, em, es;
    logic       emid, eslow;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_load(input logic [4:0] f, m, s, input logic [4:0] ef, em, es);
    load = 1'b1;
    init_fast = f;
    init_mid  = m;
    init_slow = s;
    tick();
    chk("load_rotors", {31'd0, load_rotors}, 32'd1);
    chk("load_pos", {17'd0, pos_fast, pos_mid, pos_slow}, {17'd0, ef, em, es});
    chk("load_count", {17'd0, step_count}, 32'd0);
    chk("load_sweep_done", {31'd0, sweep_done}, 32'd0);
    load = 1'b0;
  endtask

  // Bit c of each trace is the output in cycle c+1 after step_req is raised.
  task automatic run_step(output logic [5:0] tf, tm, ts, ta, tb, tl);
    step_req = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (c == 0) step_req = 1'b0;
      tf[c] = inc_fast;
      tm[c] = inc_mid;
      ts[c] = inc_slow;
      ta[c] = step_ack;
      tb[c] = busy;
      tl[c] = load_rotors;
    end
  endtask

  initial begin
    logic [5:0] tf, tm, ts, ta, tb, tl;
    int acks, last, bad_sp, bad_pos, bad_cnt, bad_done, extra_inc;
    int mf, mm, ms;

    vecs[0] = '{5'd0,  5'd0,  5'd0,  5'd1,  5'd0,  5'd0,  1'b0, 1'b0};
    vecs[1] = '{5'd25, 5'd3,  5'd7,  5'd0,  5'd4,  5'd7,  1'b1, 1'b0};
    vecs[2] = '{5'd25, 5'd25, 5'd25, 5'd0,  5'd0,  5'd0,  1'b1, 1'b1};
    vecs[3] = '{5'd30, 5'd2,  5'd26, 5'd1,  5'd2,  5'd0,  1'b0, 1'b0};
    vecs[4] = '{5'd24, 5'd25, 5'd25, 5'd25, 5'd25, 5'd25, 1'b0, 1'b0};
    vecs[5] = '{5'd25, 5'd25, 5'd3,  5'd0,  5'd0,  5'd4,  1'b1, 1'b1};
    vecs[6] = '{5'd25, 5'd24, 5'd25, 5'd0,  5'd25, 5'd25, 1'b1, 1'b0};

    resetn = 1'b0; load = 1'b0; step_req = 1'b0;
    init_fast = 5'd0; init_mid = 5'd0; init_slow = 5'd0;
    repeat (2) tick();
    chk("reset_outputs",
        {8'd0, step_ack, busy, inc_fast, inc_mid, inc_slow, load_rotors, sweep_done,
         pos_fast, pos_mid, pos_slow}, 32'd0);
    chk("reset_count", {17'd0, step_count}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    tick();

    // Single steps from a table of start positions, including carries and clamped inits.
    for (int v = 0; v < 7; v++) begin
      do_load(vecs[v].f, vecs[v].m, vecs[v].s,
              (vecs[v].f > 5'd25) ? 5'd0 : vecs[v].f,
              (vecs[v].m > 5'd25) ? 5'd0 : vecs[v].m,
              (vecs[v].s > 5'd25) ? 5'd0 : vecs[v].s);
      run_step(tf, tm, ts, ta, tb, tl);
      chk("inc_fast_trace", {26'd0, tf}, 32'b000001);
      chk("inc_mid_trace",  {26'd0, tm}, {31'd0, vecs[v].emid});
      chk("inc_slow_trace", {26'd0, ts}, {31'd0, vecs[v].eslow});
      chk("ack_trace",      {26'd0, ta}, 32'b001000);
      chk("busy_trace",     {26'd0, tb}, 32'b001111);
      chk("load_rotors_trace", {26'd0, tl}, 32'd0);
      chk("step_pos", {17'd0, pos_fast, pos_mid, pos_slow},
          {17'd0, vecs[v].ef, vecs[v].em, vecs[v].es});
      chk("step_count_1", {17'd0, step_count}, 32'd1);
    end

    // Load during the second SETTLE cycle aborts the step without an ack.
    do_load(5'd5, 5'd0, 5'd0, 5'd5, 5'd0, 5'd0);
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    tick();
    tick();
    load = 1'b1; init_fast = 5'd10; init_mid = 5'd11; init_slow = 5'd12;
    tick();
    load = 1'b0;
    chk("abort_ack", {31'd0, step_ack}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_pos", {17'd0, pos_fast, pos_mid, pos_slow}, {17'd0, 5'd10, 5'd11, 5'd12});
    chk("abort_count", {17'd0, step_count}, 32'd0);
    chk("abort_load_rotors", {31'd0, load_rotors}, 32'd1);
    tick();
    chk("abort_no_late_ack", {30'd0, step_ack, load_rotors}, 32'd0);
    run_step(tf, tm, ts, ta, tb, tl);
    chk("post_abort_ack", {26'd0, ta}, 32'b001000);
    chk("post_abort_pos", {17'd0, pos_fast, pos_mid, pos_slow}, {17'd0, 5'd11, 5'd11, 5'd12});

    // Full sweep with step_req held high.
    do_load(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
    step_req = 1'b1;
    acks = 0; last = 0; bad_sp = 0; bad_pos = 0; bad_cnt = 0; bad_done = 0;
    mf = 0; mm = 0; ms = 0;
    for (int c = 1; (c <= 17576 * 5 + 20) && (acks < 17576); c++) begin
      tick();
      if (step_ack) begin
        acks++;
        if (mf == 25) begin
          mf = 0;
          if (mm == 25) begin
            mm = 0;
            ms = (ms == 25) ? 0 : ms + 1;
          end else begin
            mm = mm + 1;
          end
        end else begin
          mf = mf + 1;
        end
        if ((acks == 1) ? (c != 4) : (c - last != 5)) bad_sp++;
        last = c;
        if ((int'(pos_fast) != mf) || (int'(pos_mid) != mm) || (int'(pos_slow) != ms)) bad_pos++;
        if (int'(step_count) != acks) bad_cnt++;
        if (sweep_done != (acks == 17576)) bad_done++;
      end
    end
    chk("sweep_acks", acks, 32'd17576);
    chk("sweep_spacing_errors", bad_sp, 32'd0);
    chk("sweep_pos_errors", bad_pos, 32'd0);
    chk("sweep_count_errors", bad_cnt, 32'd0);
    chk("sweep_done_errors", bad_done, 32'd0);
    chk("sweep_final_pos", {17'd0, pos_fast, pos_mid, pos_slow}, 32'd0);
    chk("sweep_final_count", {17'd0, step_count}, 32'd17576);
    extra_inc = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (inc_fast || busy || step_ack) extra_inc++;
    end
    chk("sweep_no_more_steps", extra_inc, 32'd0);
    chk("sweep_done_sticky", {31'd0, sweep_done}, 32'd1);
    step_req = 1'b0;
    do_load(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);

    // Load with out-of-range init and step_req together, then async reset mid-SETTLE.
    load = 1'b1; step_req = 1'b1;
    init_fast = 5'd30; init_mid = 5'd1; init_slow = 5'd2;
    tick();
    load = 1'b0;
    chk("clamp_pos_fast", {27'd0, pos_fast}, 32'd0);
    chk("load_beats_step", {29'd0, inc_fast, inc_mid, busy}, 32'd0);
    chk("load_rotors_alone", {31'd0, load_rotors}, 32'd1);
    tick();
    step_req = 1'b0;
    chk("pulse_after_load", {31'd0, inc_fast}, 32'd1);
    chk("no_overlap_inc_load", {31'd0, load_rotors}, 32'd0);
    tick();
    #2;
    resetn = 1'b0;
    #1;
    chk("async_reset_outputs",
        {8'd0, step_ack, busy, inc_fast, inc_mid, inc_slow, load_rotors, sweep_done,
         pos_fast, pos_mid, pos_slow}, 32'd0);
    chk("async_reset_count", {17'd0, step_count}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) tick();
    chk("after_reset_idle", {30'd0, busy, step_ack}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rotor_step_controller.md
Name: rotor_step_controller

Overview:
- Drives the stepping of a three-drum bombe rotor stack (fast, middle, slow), each with positions 0..25.
- Accepts one step request at a time and issues one-cycle increment pulses to the drums, with odometer carry.
- Keeps shadow copies of the drum positions, waits a settle interval, then acknowledges the step.
- Sits upstream of the clocked rotors: it generates the increments and load values that those rotors consume.

Parameters:
SETTLE_CYCLES, 2, cycles spent in SETTLE after the increment pulse before step_ack (0 allowed = no SETTLE state)
SWEEP_LEN, 17576, steps in a full sweep (26^3); step_count saturates here

Ports:
clk  input  1  system clock, rising edge
resetn  input  1  asynchronous reset, active-low
load  input  1  synchronous load of init positions; priority over everything except resetn
init_fast  input  5  initial fast drum position
init_mid  input  5  initial middle drum position
init_slow  input  5  initial slow drum position
step_req  input  1  level request for one step; sampled only in IDLE
step_ack  output  1  one-cycle pulse: step complete, positions stable
busy  output  1  high in PULSE, SETTLE and ACK
inc_fast  output  1  one-cycle increment pulse to fast drum
inc_mid  output  1  one-cycle increment pulse to middle drum
inc_slow  output  1  one-cycle increment pulse to slow drum
load_rotors  output  1  one-cycle pulse to drum load inputs, one cycle after load is sampled
pos_fast  output  5  shadow fast position, 0..25
pos_mid  output  5  shadow middle position, 0..25
pos_slow  output  5  shadow slow position, 0..25
step_count  output  15  steps since last load, saturating at SWEEP_LEN
sweep_done  output  1  sticky; set when step_count reaches SWEEP_LEN

Behaviour:
- Reset (resetn=0, async): state IDLE. All outputs 0, all positions 0, step_count 0, sweep_done 0, settle counter 0.
- States and transitions:
  - IDLE: if load, do the load action and stay IDLE. Else if step_req and not sweep_done, go to PULSE. Otherwise stay.
  - PULSE: lasts 1 cycle. inc_* decoded combinationally from state and current positions.
  - PULSE goes to SETTLE if SETTLE_CYCLES>0, else to ACK.
  - SETTLE: lasts exactly SETTLE_CYCLES cycles, then ACK.
  - ACK: step_ack=1 for 1 cycle, then IDLE.
- Load action: positions <= init values, step_count <= 0, sweep_done <= 0, load_rotors = 1 in the next cycle.
- Init values 26..31 are loaded as 0.
- Load in PULSE, SETTLE or ACK: abort and go to IDLE. No step_ack is issued for the aborted step. Load action as above.
- Increment rules in PULSE:
  - inc_fast = 1 always.
  - inc_mid = 1 iff pos_fast==25.
  - inc_slow = 1 iff pos_fast==25 and pos_mid==25.
- Position update: at the end of PULSE each pulsed drum position goes +1, with 25 wrapping to 0. step_count goes +1.
- sweep_done: when step_count becomes SWEEP_LEN, sweep_done is set at the same edge.
  - After this, positions again equal the init values.
  - step_req is ignored (no PULSE) until load.
- Latency: step_req high in IDLE at cycle 0 gives PULSE in cycle 1 and step_ack in cycle 2+SETTLE_CYCLES (cycle 4 by default).
- Back-to-back: with step_req held high, a new PULSE starts every 3+SETTLE_CYCLES cycles. step_req is not sampled in the ACK cycle.
- Simultaneous events:
  - load and step_req in the same IDLE cycle: load wins and no pulse is issued.
  - resetn overrides all.
- inc_* and load_rotors are never high in the same cycle.
- At most one step is in flight at any time.

Test Plan:
1. Reset, load 0/0/0, assert step_req for 1 cycle at cycle 0:
   - inc_fast=1 only in cycle 1, busy cycles 1-4, step_ack in cycle 4.
   - Then pos=1/0/0, step_count=1.
2. Load fast=25, mid=3, slow=7, then step:
   - inc_fast and inc_mid both high in the PULSE cycle, inc_slow=0.
   - Then pos=0/4/7.
3. Load 25/25/25, then step:
   - All three inc pulses in the same cycle.
   - Then pos=0/0/0, step_count=1.
4. Load 0/0/0 and hold step_req high:
   - Exactly 17576 step_acks, spaced 5 cycles apart.
   - sweep_done=1 at the final ack edge, pos=0/0/0, step_count=17576.
   - No further inc pulses while step_req stays high.
   - A subsequent load clears sweep_done.
5. Start a step from pos 5/0/0, assert load with init 10/11/12 during the second SETTLE cycle:
   - No step_ack; state returns to IDLE.
   - pos=10/11/12, step_count=0, load_rotors pulses next cycle.
6. Load with init_fast=30 and step_req high in the same cycle:
   - pos_fast=0, no inc pulse in the following cycle.
   - Then pulse resetn low mid-SETTLE: all outputs 0 immediately, without waiting for a clock edge.
